// File: rtl/debug_clk_ctrl_pkg.sv
// Shared command codes, response bytes and FSM encodings for the debug clock command front-end.
// No logic; constants only.
package debug_clk_ctrl_pkg;

    localparam logic [7:0] CMD_DIV  = 8'h44;  // 'D'
    localparam logic [7:0] CMD_MODE = 8'h4D;  // 'M'
    localparam logic [7:0] CMD_STEP = 8'h53;  // 'S'
    localparam logic [7:0] CMD_STAT = 8'h3F;  // '?'
    localparam logic [7:0] ACK      = 8'h06;
    localparam logic [7:0] NAK      = 8'h15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARG,
        ST_EXEC,
        ST_STEP,
        ST_RESP
    } state_t;

    typedef enum logic [1:0] {
        PG_IDLE,
        PG_HI,
        PG_LO
    } pg_state_t;

endpackage

// File: rtl/debug_clk_ctrl_step_pulse_gen.sv
// Emits N pulses, PULSE_CYCLES high then PULSE_CYCLES low each; first pulse rises the cycle after start.
// done strobes during the last low cycle; no backpressure, start is ignored while running.
module step_pulse_gen
    import debug_clk_ctrl_pkg::*;
#(
    parameter int PULSE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] count,
    output logic       pulse,
    output logic       done
);

    localparam int CW = $clog2(PULSE_CYCLES + 1);

    pg_state_t      phase, phase_nxt;
    logic [CW-1:0]  cnt;
    logic [7:0]     left;
    logic           cnt_last;

    assign cnt_last = (cnt == CW'(PULSE_CYCLES - 1));

    always_comb begin
        phase_nxt = phase;
        done      = 1'b0;
        case (phase)
            PG_IDLE: if (start && count != 8'd0) phase_nxt = PG_HI;
            PG_HI:   if (cnt_last) phase_nxt = PG_LO;
            PG_LO: begin
                if (cnt_last) begin
                    if (left == 8'd1) begin
                        done      = 1'b1;
                        phase_nxt = PG_IDLE;
                    end else begin
                        phase_nxt = PG_HI;
                    end
                end
            end
            default: phase_nxt = PG_IDLE;
        endcase
    end

    // pulse is its own flop so the divider never sees a decode glitch
    always_ff @(posedge clk) begin
        if (reset) begin
            phase <= PG_IDLE;
            cnt   <= '0;
            left  <= 8'd0;
            pulse <= 1'b0;
        end else begin
            phase <= phase_nxt;
            pulse <= (phase_nxt == PG_HI);
            if (phase_nxt != phase || phase == PG_IDLE)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
            if (phase == PG_IDLE && start)
                left <= count;
            else if (phase == PG_LO && cnt_last)
                left <= left - 8'd1;
        end
    end

endmodule

// File: rtl/debug_clk_ctrl.sv
// UART command parser driving the debug clock divider; registers commit 1 cycle after the last arg byte.
// RX has no backpressure (bytes outside IDLE/ARG are dropped); the reply byte is held until tx_ready.
module debug_clk_ctrl
    import debug_clk_ctrl_pkg::*;
#(
    parameter int          COUNTER_BITS    = 32,
    parameter logic [31:0] DEFAULT_DIVIDER = 32'd100,
    parameter int          PULSE_CYCLES    = 4,
    parameter int          TIMEOUT_CYCLES  = 1_000_000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic [7:0]              tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic                    option,
    output logic                    out_enable,
    output logic [COUNTER_BITS-1:0] divider,
    output logic                    pulse,
    output logic                    busy
);

    localparam int NB = COUNTER_BITS / 8;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t                  state, state_nxt;
    logic [7:0]              cmd;
    logic [COUNTER_BITS-1:0] arg;
    logic [1:0]              arg_idx, arg_need;
    logic [TW-1:0]           tmo_cnt;
    logic                    arg_last, tmo_hit;
    logic                    step_start, step_done;

    assign arg_last = rx_valid && (arg_idx == arg_need);
    assign tmo_hit  = !rx_valid && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign tx_valid = (state == ST_RESP);
    assign busy     = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        step_start = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rx_valid) begin
                    if (rx_data == CMD_DIV || rx_data == CMD_MODE || rx_data == CMD_STEP)
                        state_nxt = ST_ARG;
                    else
                        state_nxt = ST_RESP;
                end
            end
            ST_ARG: begin
                if (arg_last)     state_nxt = ST_EXEC;
                else if (tmo_hit) state_nxt = ST_RESP;
            end
            ST_EXEC: begin
                if (cmd == CMD_STEP && arg[7:0] != 8'd0) begin
                    step_start = 1'b1;
                    state_nxt  = ST_STEP;
                end else begin
                    state_nxt = ST_RESP;
                end
            end
            ST_STEP: if (step_done) state_nxt = ST_RESP;
            ST_RESP: if (tx_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cmd        <= 8'd0;
            arg        <= '0;
            arg_idx    <= 2'd0;
            arg_need   <= 2'd0;
            tmo_cnt    <= '0;
            tx_data    <= 8'd0;
            option     <= 1'b0;
            out_enable <= 1'b0;
            divider    <= DEFAULT_DIVIDER[COUNTER_BITS-1:0];
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rx_valid) begin
                        cmd      <= rx_data;
                        arg      <= '0;
                        arg_idx  <= 2'd0;
                        arg_need <= (rx_data == CMD_DIV) ? 2'(NB - 1) : 2'd0;
                        tmo_cnt  <= '0;
                        if (rx_data == CMD_STAT)
                            tx_data <= {6'b0, out_enable, option};
                        else
                            tx_data <= NAK;
                    end
                end
                ST_ARG: begin
                    if (rx_valid) begin
                        arg[8*arg_idx +: 8] <= rx_data;
                        arg_idx             <= arg_idx + 2'd1;
                        tmo_cnt             <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_EXEC: begin
                    // every argument lands on this single edge so the divider never sees a half-written value
                    tx_data <= ACK;
                    if (cmd == CMD_DIV)
                        divider <= (arg < COUNTER_BITS'(2)) ? COUNTER_BITS'(2) : arg;
                    if (cmd == CMD_MODE) begin
                        option     <= arg[0];
                        out_enable <= arg[1];
                    end
                end
                default: ;
            endcase
        end
    end

    step_pulse_gen #(
        .PULSE_CYCLES (PULSE_CYCLES)
    ) u_step (
        .clk   (clk),
        .reset (reset),
        .start (step_start),
        .count (arg[7:0]),
        .pulse (pulse),
        .done  (step_done)
    );

endmodule

// File: tb/tb_debug_clk_ctrl.sv
// Directed plus randomized command streams against a register-level model of the debug clock front-end.
module tb_debug_clk_ctrl;

    localparam int PC  = 4;
    localparam int TMO = 200;
    localparam logic [7:0] C_D = 8'h44, C_M = 8'h4D, C_S = 8'h53, C_Q = 8'h3F;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        option;
    logic        out_enable;
    logic [31:0] divider;
    logic        pulse;
    logic        busy;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_div;
    logic        m_opt, m_oe;

    debug_clk_ctrl #(
        .COUNTER_BITS    (32),
        .DEFAULT_DIVIDER (32'd100),
        .PULSE_CYCLES    (PC),
        .TIMEOUT_CYCLES  (TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .option     (option),
        .out_enable (out_enable),
        .divider    (divider),
        .pulse      (pulse),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic handshake();
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        chk("idle_after_hs", {30'd0, busy, tx_valid}, 32'd0);
    endtask

    task automatic check_regs(input string tag);
        chk({tag, "_div"}, divider, m_div);
        chk({tag, "_mode"}, {30'd0, out_enable, option}, {30'd0, m_oe, m_opt});
    endtask

    // Issue one command, predict reply/latency/pulse train from the command rules, then check.
    task automatic run_cmd(input logic [7:0] c, input logic [31:0] v);
        int          nb, lat, exp_lat, n, pulse_err, busy_err, idx;
        logic [7:0]  exp_tx;
        logic        exp_p;
        nb = (c == C_D) ? 4 : ((c == C_M || c == C_S) ? 1 : 0);
        n  = 0;
        send_byte(c);
        for (int i = 0; i < nb; i++) send_byte(v[8*i +: 8]);
        case (c)
            C_D: begin m_div = (v < 2) ? 32'd2 : v; exp_tx = 8'h06; exp_lat = 1; end
            C_M: begin m_opt = v[0]; m_oe = v[1]; exp_tx = 8'h06; exp_lat = 1; end
            C_S: begin n = int'(v[7:0]); exp_tx = 8'h06; exp_lat = 1 + 2 * n * PC; end
            C_Q: begin exp_tx = {6'b0, m_oe, m_opt}; exp_lat = 0; end
            default: begin exp_tx = 8'h15; exp_lat = 0; end
        endcase
        lat = 0; pulse_err = 0; busy_err = 0;
        while (!tx_valid && lat < 3000) begin
            if (busy !== 1'b1) busy_err++;
            idx   = lat - 1;
            exp_p = (lat >= 1) && (idx < 2 * n * PC) && ((idx / PC) % 2 == 0);
            if (pulse !== exp_p) pulse_err++;
            @(negedge clk);
            lat++;
        end
        chk($sformatf("lat_%h", c), lat, exp_lat);
        chk($sformatf("tx_%h", c), {24'd0, tx_data}, {24'd0, exp_tx});
        if (c == C_S) begin
            chk("pulse_train", pulse_err, 0);
            chk("busy_step", busy_err, 0);
        end
        handshake();
        check_regs($sformatf("regs_%h", c));
    endtask

    initial begin
        int          lat, stable_err;
        logic [7:0]  saved, u;
        logic [31:0] r;

        reset = 1'b1; rx_data = 8'd0; rx_valid = 1'b0; tx_ready = 1'b0;
        m_div = 32'd100; m_opt = 1'b0; m_oe = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_div", divider, 32'd100);
        chk("rst_opt", {31'd0, option}, 32'd0);
        chk("rst_oe", {31'd0, out_enable}, 32'd0);
        chk("rst_pulse", {31'd0, pulse}, 32'd0);
        chk("rst_txv", {31'd0, tx_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);

        run_cmd(C_D, 32'd10000);
        run_cmd(C_D, 32'd1);
        run_cmd(C_M, 32'd3);
        run_cmd(C_Q, 32'd0);
        run_cmd(C_S, 32'd3);
        run_cmd(C_S, 32'd0);
        run_cmd(8'h58, 32'd0);

        // argument stall: abort with NAK, divider untouched
        send_byte(C_D);
        send_byte(8'h01);
        lat = 0;
        while (!tx_valid && lat < 1000) begin @(negedge clk); lat++; end
        chk("tmo_latency_ok", {31'd0, (lat >= TMO - 1 && lat <= TMO + 1)}, 32'd1);
        chk("tmo_nak", {24'd0, tx_data}, 32'h15);
        handshake();
        check_regs("tmo");

        // reply held for 50 cycles while stray bytes arrive; none may take effect
        send_byte(C_M);
        send_byte(8'h02);
        m_opt = 1'b0; m_oe = 1'b1;
        @(negedge clk);
        saved = tx_data; stable_err = 0;
        for (int i = 0; i < 50; i++) begin
            rx_data  = (i % 2 == 0) ? C_M : 8'h01;
            rx_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (tx_data !== saved || tx_valid !== 1'b1) stable_err++;
        end
        rx_valid = 1'b0;
        chk("hold_ack", {24'd0, saved}, 32'h06);
        chk("hold_stable", stable_err, 0);
        handshake();
        check_regs("hold");
        run_cmd(C_Q, 32'd0);

        // randomized command mix
        for (int k = 0; k < 16; k++) begin
            r = $urandom;
            case ($urandom_range(0, 4))
                0: run_cmd(C_D, ($urandom_range(0, 2) == 0) ? {30'd0, r[1:0]} : r);
                1: run_cmd(C_M, r);
                2: run_cmd(C_S, {29'd0, r[2:0]});
                3: run_cmd(C_Q, r);
                default: begin
                    u = r[7:0];
                    if (u == C_D || u == C_M || u == C_S || u == C_Q) u = 8'h00;
                    run_cmd(u, r);
                end
            endcase
        end

        // reset in the middle of a step burst
        send_byte(C_S);
        send_byte(8'd10);
        lat = 0;
        while (pulse !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_pulse", {31'd0, pulse}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_txv", {31'd0, tx_valid}, 32'd0);
        reset = 1'b0;
        m_div = 32'd100; m_opt = 1'b0; m_oe = 1'b0;
        check_regs("midrst");
        run_cmd(C_Q, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
